// File: rtl/seed_prng.sv
// seed_prng: xorshift128+ pseudo-random generator with reseed and step counter.
//
// Ports:
//   clk       - sole clock; all state changes on its rising edge
//   rst       - synchronous active-high reset
//   free_run  - advance state every cycle while high
//   req       - one-cycle request for a new random value (advances one step)
//   reseed    - load seed_x/seed_y into the state; outranks req and free_run
//   seed_x/y  - reseed values; an all-zero pair selects SEED_X/SEED_Y instead
//   rnd       - low OUT_W bits of the sum captured on the last req step
//   valid     - one-cycle pulse marking an rnd update
//   x, y      - current 64-bit state words
//   steps     - state advances since reset or reseed; wraps silently
module seed_prng #(
  parameter logic [63:0] SEED_X = 64'h3A71628D53C493E6,
  parameter logic [63:0] SEED_Y = 64'hFA276435902E7342,
  parameter int unsigned OUT_W  = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             free_run,
  input  logic             req,
  input  logic             reseed,
  input  logic [63:0]      seed_x,
  input  logic [63:0]      seed_y,
  output logic [OUT_W-1:0] rnd,
  output logic             valid,
  output logic [63:0]      x,
  output logic [63:0]      y,
  output logic [CNT_W-1:0] steps
);

  logic [63:0]      x_q, x_d;
  logic [63:0]      y_q, y_d;
  logic [OUT_W-1:0] rnd_q, rnd_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] steps_q, steps_d;

  logic [63:0]      t;
  logic [63:0]      y_adv;
  logic [OUT_W-1:0] sum_lo;
  logic             seed_zero;

  // One xorshift128+ step: s1 = x, s0 = y.
  always_comb begin
    t      = x_q ^ (x_q << 23);
    y_adv  = t ^ y_q ^ (t >> 17) ^ (y_q >> 26);
    // Low bits of a sum depend only on low bits of the operands, so only the
    // visible slice is added; the carry out is discarded.
    sum_lo = y_adv[OUT_W-1:0] + y_q[OUT_W-1:0];
  end

  assign seed_zero = (seed_x == 64'd0) && (seed_y == 64'd0);

  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    rnd_d   = rnd_q;
    valid_d = 1'b0;
    steps_d = steps_q;
    if (reseed) begin
      // A coincident req is dropped: no step, no valid.
      x_d     = seed_zero ? SEED_X : seed_x;
      y_d     = seed_zero ? SEED_Y : seed_y;
      steps_d = '0;
    end else if (free_run || req) begin
      // req and free_run together still advance exactly one step.
      x_d     = y_q;
      y_d     = y_adv;
      steps_d = steps_q + CNT_W'(1);
      if (req) begin
        rnd_d   = sum_lo;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q     <= SEED_X;
      y_q     <= SEED_Y;
      rnd_q   <= '0;
      valid_q <= 1'b0;
      steps_q <= '0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      rnd_q   <= rnd_d;
      valid_q <= valid_d;
      steps_q <= steps_d;
    end
  end

  assign x     = x_q;
  assign y     = y_q;
  assign rnd   = rnd_q;
  assign valid = valid_q;
  assign steps = steps_q;

endmodule

// File: doc/seed_prng.md
SEED_PRNG -- requirements
Module: seed_prng

Interface
REQ-001 The block SHALL have parameter SEED_X, default 64'h3A71628D53C493E6, power-on/reset value of state word x.
REQ-002 The block SHALL have parameter SEED_Y, default 64'hFA276435902E7342, power-on/reset value of state word y.
REQ-003 The block SHALL have parameter OUT_W, default 4, width of rnd (1..64).
REQ-004 The block SHALL have parameter CNT_W, default 16, width of the step counter.
REQ-005 The block SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-007 The block SHALL have port free_run, input, 1, when high the state advances every cycle.
REQ-008 The block SHALL have port req, input, 1, one-cycle request for a new random value.
REQ-009 The block SHALL have port reseed, input, 1, load seed_x/seed_y into state.
REQ-010 The block SHALL have ports seed_x and seed_y, input, 64 each, reseed values.
REQ-011 The block SHALL have port rnd, output, OUT_W, low OUT_W bits of the captured xorshift128+ sum.
REQ-012 The block SHALL have port valid, output, 1, one-cycle pulse marking rnd updated.
REQ-013 The block SHALL have ports x and y, output, 64 each, current state words.
REQ-014 The block SHALL have port steps, output, CNT_W, count of state advances since reset or reseed.

Function
REQ-015 One step SHALL compute: s1=x, s0=y; x_next=s0; t=s1^(s1<<23); y_next=t^s0^(t>>17)^(s0>>26); sum=y_next+s0 (mod 2^64).
REQ-016 The state SHALL advance one step in a cycle where (free_run | req) is high and reseed and rst are low; otherwise x, y SHALL hold.
REQ-017 On a req cycle, the next edge SHALL register rnd = sum[OUT_W-1:0] of that step and set valid=1 for exactly one cycle (latency 1).
REQ-018 Back-to-back req SHALL yield valid every cycle with successive sums; no request SHALL be dropped or merged.
REQ-019 In non-req cycles valid SHALL be 0 and rnd SHALL hold its last value.
REQ-020 free_run without req SHALL advance x, y and steps but SHALL NOT change rnd or valid.
REQ-021 req together with free_run SHALL advance exactly one step, not two.
REQ-022 reseed SHALL load x=seed_x, y=seed_y and clear steps to 0 at the next edge; it SHALL take priority over req and free_run, and a coincident req SHALL be dropped (valid=0).
REQ-023 If seed_x and seed_y are both zero at reseed, the block SHALL load SEED_X/SEED_Y instead (the all-zero state is forbidden).
REQ-024 steps SHALL increment by 1 per step and wrap from 2^CNT_W-1 to 0 with no flag.
REQ-025 All arithmetic SHALL be unsigned, with shifts logical and zero-filling and the carry from the 64-bit sum discarded.

Reset
REQ-026 rst SHALL take priority over all inputs: x=SEED_X, y=SEED_Y, rnd=0, valid=0, steps=0 at the next edge.
REQ-027 rst asserted in the cycle after a req SHALL force valid=0 and discard the pending result; state SHALL return to the seeds.

Verification
REQ-028 Assert rst 1 cycle -> x=64'h3A71628D53C493E6, y=64'hFA276435902E7342, rnd=0, valid=0, steps=0.
REQ-029 reseed with seed_x=1 and seed_y=2, then req 1 cycle -> next cycle x=2, y=64'h800043, rnd=4'h5 (sum 64'h800045), valid=1, steps=1.
REQ-030 reseed with seed_x=0 and seed_y=0 -> x and y equal SEED_X and SEED_Y, steps=0.
REQ-031 reseed, req and free_run all high together -> seed loaded, valid=0, steps=0.
REQ-032 free_run high for 10 cycles with req low -> steps=10, rnd unchanged, valid never 1; x and y match the reference model after 10 steps.
REQ-033 CNT_W=4 with free_run high for 17 cycles -> steps=1 (wrap); req on 3 consecutive cycles -> 3 consecutive valid pulses matching the model.
